// File: rtl/uart_rx_core.sv
// UART receive front-end: 2-flop synchronizer, mid-bit sampling FSM, valid/ready word output.
// Optional parity bit support is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_core #(
  parameter int DATA_W = 8,
  parameter int CDR_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rx_en,
  input  logic [CDR_W-1:0]  cdr,
  input  logic              parity_odd,
  input  logic              uart_rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun_err
);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HI} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;
`endif

  state_t              state, state_nxt;
  logic                rx_s1, rxs;
  logic [CDR_W-1:0]    cnt, cdr_l;
  logic [3:0]          bit_cnt;
  logic [DATA_W-1:0]   shreg;
  logic                par_bad;
  logic                samp, stop_samp, deliver, ferr_set;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // rx_en low forces IDLE from any state on the next edge
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (~rxs) state_nxt = START;
      START:   if (samp) state_nxt = rxs ? IDLE : DATA;
      DATA:
        if (samp && bit_cnt == 4'(DATA_W - 1)) begin
`ifdef UART_RX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
      PARITY:  if (samp) state_nxt = STOP;
`endif
      STOP:    if (samp) state_nxt = rxs ? IDLE : WAIT_HI;
      WAIT_HI: if (rxs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (!rx_en) state_nxt = IDLE;
  end

  always_comb begin
    samp = 1'b0;
    case (state)
      START:   samp = (cnt == (cdr_l >> 1));
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP:    samp = (cnt == cdr_l);
      default: samp = 1'b0;
    endcase
    stop_samp = rx_en & (state == STOP) & samp;
    deliver   = stop_samp & rxs & ~par_bad;
    ferr_set  = stop_samp & ~rxs;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_s1   <= 1'b1;
      rxs     <= 1'b1;
      cnt     <= '0;
      cdr_l   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      rx_s1 <= uart_rx;
      rxs   <= rx_s1;
      if (!rx_en) begin
        cnt     <= '0;
        bit_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            cnt     <= '0;
            bit_cnt <= '0;
            if (~rxs) cdr_l <= cdr;
          end
          WAIT_HI: cnt <= '0;
          default: cnt <= samp ? '0 : cnt + 1'b1;
        endcase
        if (state == DATA && samp) begin
          shreg   <= {rxs, shreg[DATA_W-1:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_acc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      par_acc <= 1'b0;
      par_bad <= 1'b0;
    end else if (state == IDLE) begin
      par_acc <= 1'b0;
      par_bad <= 1'b0;
    end else if (state == DATA && samp) begin
      par_acc <= par_acc ^ rxs;
    end else if (state == PARITY && samp) begin
      par_bad <= ((par_acc ^ rxs) != parity_odd);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) parity_err <= 1'b0;
    else       parity_err <= stop_samp & rxs & par_bad;
  end
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
  assign par_bad           = 1'b0;
  assign parity_err        = 1'b0;
`endif

  // a same-edge accept frees the slot, so the new word lands without overrun
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= ferr_set;
      overrun_err <= deliver & rx_valid & ~rx_ready;
      if (deliver && (!rx_valid || rx_ready)) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Serial receive front-end for the UART peripheral: it recovers asynchronous frames from the `uart_rx` pin and presents complete data words to the register/FIFO layer through a valid/ready handshake. It sits directly upstream of the bus-side UART register block (simple/APB/AHB/Avalon wrappers) and drives that block's receive status flags and receive interrupt sources.

## Interface
Parameters:
- `DATA_W`, 8, data bits per frame, legal 5..9, sent LSB first
- `CDR_W`, 16, width of the clock divider ratio

Ports:
- `clk`  in  1  system clock
- `rstn`  in  1  reset; asynchronous, active-low
- `rx_en`  in  1  receiver enable; 0 aborts any frame and holds the FSM in IDLE
- `cdr`  in  CDR_W  bit period minus one, in `clk` cycles; must be >= 3
- `parity_odd`  in  1  1 = odd parity, 0 = even; used only with `UART_RX_PARITY_EN`
- `uart_rx`  in  1  serial line, asynchronous, idle high
- `rx_data`  out  DATA_W  received word
- `rx_valid`  out  1  `rx_data` holds an unread word
- `rx_ready`  in  1  consumer accepts the word when `rx_valid & rx_ready`
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low
- `parity_err`  out  1  one-cycle pulse: parity mismatch
- `overrun_err`  out  1  one-cycle pulse: frame completed while `rx_valid` was still 1

## Operation
- `uart_rx` passes through a 2-flop synchronizer (both flops reset to 1); all decisions use the synchronized value `rxs`.
- `cdr` is latched into `cdr_l` on start detection; changes mid-frame take effect on the next frame.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_HI.
- IDLE: if `rx_en & ~rxs`, load `cnt` with 0 and go to START.
- START: when `cnt == cdr_l>>1`, sample. If `rxs == 1` (false start), go to IDLE. Otherwise load `cnt` with 0 and go to DATA. In any other cycle, `cnt` increments.
- DATA/PARITY/STOP: sample when `cnt == cdr_l` (one full bit period after the previous sample), then load `cnt` with 0. In any other cycle, `cnt` increments.
- DATA shifts in DATA_W bits LSB first, then goes to PARITY or STOP.
- STOP, `rxs == 1`:
  - error-free frame: deliver the word, go to IDLE (the next start may be detected during the second half of the stop bit);
  - parity error: pulse `parity_err`, drop the word, go to IDLE.
- STOP, `rxs == 0`: pulse `frame_err`, drop the word, go to WAIT_HI.
- WAIT_HI: remain until `rxs == 1`, then go to IDLE. This prevents a held-low or break line from retriggering.
- Deliver:
  - if `rx_valid == 0`, load `rx_data` and set `rx_valid`;
  - else pulse `overrun_err` and keep the old `rx_data` (new word lost).
- `rx_valid` clears on the cycle after `rx_valid & rx_ready`.
- Delivery and the accept/clear of `rx_valid` are evaluated on the same edge. If `rx_valid & rx_ready` on the delivery edge, the new word is loaded, `rx_valid` stays 1, and there is no overrun.
- `rx_en` low in any state: the next edge goes to IDLE with no output and no error pulse. `rx_valid` and `rx_data` are untouched.
- Error pulses are mutually exclusive per frame. Priority: frame > parity > overrun.

## Timing
- Reset values: `rx_data` = 0, `rx_valid` = 0, `frame_err` = `parity_err` = `overrun_err` = 0, FSM = IDLE, `cnt` = 0.
- Synchronizer latency: 2 cycles from pin to `rxs`.
- Let D be the IDLE detection edge and P = 1 with parity enabled, else 0.
- The start sample occurs at edge D+(cdr>>1)+1.
- Data bit k (k = 1..DATA_W) is sampled at edge D+(cdr>>1)+1+k(cdr+1).
- `rx_valid` or an error pulse is registered at the stop-sample edge, D+(cdr>>1)+1+(DATA_W+P+1)(cdr+1).
- `cnt` is CDR_W bits wide and never wraps within a legal frame.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state compiled in;
  - the parity bit follows the data bits;
  - even parity: XOR of data and parity bit must be 0; odd parity: it must be 1.
- `UART_RX_PARITY_EN` not defined:
  - no PARITY state, so the frame is start + DATA_W + stop;
  - `parity_odd` is ignored;
  - `parity_err` is tied to 0.

## Test plan
- Frame 0xA5, cdr = 9, `rx_ready` = 0 → `rx_data` = 0xA5 and `rx_valid` = 1 at edge D+95; `rx_valid` stays 1 until `rx_ready` = 1, then clears one cycle later.
- 3-cycle low glitch on an idle line, cdr = 9 → false start, FSM back to IDLE, no `rx_valid` and no error pulse.
- Frame 0x3C with stop bit driven 0, then line held low 50 cycles → one `frame_err` pulse, no `rx_valid`, no retrigger until the line returns high; a following frame 0x11 is received correctly.
- Frames 0x01 then 0x02 back-to-back with `rx_ready` = 0 → `rx_data` = 0x01, a single `overrun_err` pulse at the second stop sample.
- With the macro defined, `parity_odd` = 0, frame 0x07 with parity bit 0 → `parity_err` pulse, word dropped; the same frame with parity bit 1 → `rx_data` = 0x07.
- Deassert `rx_en` at data bit 4, reassert, then send 0x5A → no output from the aborted frame, 0x5A delivered; assert `rstn` low mid-frame → all outputs return to their reset values immediately.
